epidemic_sequencer: RTL and testbench

- Controller for an array of N_NODES SIS agents sharing one address/seed/state configuration bus.
- On start it loads each agent's recovery-PRBS seed, then loads each agent's initial state, then runs the simulation and samples the agent state vector once per clock.
- Reports per-step infected count, peak infection, and termination cause (step limit or extinction).
- Sits between the host/testbench and the agent grid.

---
 rtl/epidemic_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_epidemic_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/epidemic_sequencer.sv
// Sequences seed and state loads onto an SIS agent config bus, then samples the agent grid per clock.
// Outputs are registered; tracks infected count, peak and termination cause; start is ignored while busy.
module epidemic_sequencer #(
  parameter int          N_NODES     = 4,
  parameter int          ADDR_W      = 2,
  parameter int          CNT_W       = 3,
  parameter logic [31:0] SEED_STRIDE = 32'h9E3779B9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       baseSeed,
  input  logic [N_NODES-1:0] infMask,
  input  logic [15:0]       maxSteps,
  input  logic [N_NODES-1:0] nodeState,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       seedValue,
  output logic              loadSeed,
  output logic              initState,
  output logic              loadState,
  output logic              busy,
  output logic              done,
  output logic              extinct,
  output logic [15:0]       stepCount,
  output logic [CNT_W-1:0]  infectedCount,
  output logic [CNT_W-1:0]  peakCount,
  output logic [15:0]       peakStep
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_SEED,
    S_LOAD_STATE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_NODES - 1);

  state_t              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [N_NODES-1:0]  mask_q;
  logic [15:0]         maxSteps_q;
  logic [31:0]         seedAcc_q;
  logic [ADDR_W-1:0]   address_q;
  logic [31:0]         seedValue_q;
  logic                loadSeed_q;
  logic                initState_q;
  logic                loadState_q;
  logic                busy_q;
  logic                done_q;
  logic                extinct_q;
  logic [15:0]         stepCount_q;
  logic [CNT_W-1:0]    infectedCount_q;
  logic [CNT_W-1:0]    peakCount_q;
  logic [15:0]         peakStep_q;

  logic [CNT_W-1:0]    pop_d;
  logic [15:0]         step_d;
  logic [ADDR_W-1:0]   idx_d;

  // An all-zero seed would lock the agents' PRBS, so it is replaced with 1.
  function automatic logic [31:0] nz_seed(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  always_comb begin
    pop_d = '0;
    for (int i = 0; i < N_NODES; i++) begin
      pop_d = pop_d + CNT_W'(nodeState[i]);
    end
    step_d = (stepCount_q == 16'hFFFF) ? stepCount_q : stepCount_q + 16'd1;
    idx_d  = idx_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      mask_q          <= '0;
      maxSteps_q      <= '0;
      seedAcc_q       <= '0;
      address_q       <= '0;
      seedValue_q     <= '0;
      loadSeed_q      <= 1'b0;
      initState_q     <= 1'b0;
      loadState_q     <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      extinct_q       <= 1'b0;
      stepCount_q     <= '0;
      infectedCount_q <= '0;
      peakCount_q     <= '0;
      peakStep_q      <= '0;
    end else begin
      done_q      <= 1'b0;
      loadSeed_q  <= 1'b0;
      loadState_q <= 1'b0;
      initState_q <= 1'b0;
      address_q   <= '0;
      seedValue_q <= '0;
      case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          if (start) begin
            state_q         <= S_LOAD_SEED;
            idx_q           <= '0;
            mask_q          <= infMask;
            maxSteps_q      <= maxSteps;
            seedAcc_q       <= baseSeed + SEED_STRIDE;
            busy_q          <= 1'b1;
            loadSeed_q      <= 1'b1;
            seedValue_q     <= nz_seed(baseSeed);
            extinct_q       <= 1'b0;
            stepCount_q     <= '0;
            infectedCount_q <= '0;
            peakCount_q     <= '0;
            peakStep_q      <= '0;
          end
        end
        S_LOAD_SEED: begin
          if (idx_q == LAST_IDX) begin
            state_q     <= S_LOAD_STATE;
            idx_q       <= '0;
            loadState_q <= 1'b1;
            initState_q <= mask_q[0];
          end else begin
            idx_q       <= idx_d;
            address_q   <= idx_d;
            loadSeed_q  <= 1'b1;
            seedValue_q <= nz_seed(seedAcc_q);
            seedAcc_q   <= seedAcc_q + SEED_STRIDE;
          end
        end
        S_LOAD_STATE: begin
          if (idx_q == LAST_IDX) begin
            idx_q <= '0;
            if (maxSteps_q == 16'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_RUN;
            end
          end else begin
            idx_q       <= idx_d;
            address_q   <= idx_d;
            loadState_q <= 1'b1;
            initState_q <= mask_q[idx_d];
          end
        end
        S_RUN: begin
          infectedCount_q <= pop_d;
          stepCount_q     <= step_d;
          // Strict compare keeps the earliest step at which the peak occurred.
          if (pop_d > peakCount_q) begin
            peakCount_q <= pop_d;
            peakStep_q  <= step_d;
          end
          if (pop_d == '0) begin
            extinct_q <= 1'b1;
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
          end else if (step_d == maxSteps_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign address       = address_q;
  assign seedValue     = seedValue_q;
  assign loadSeed      = loadSeed_q;
  assign initState     = initState_q;
  assign loadState     = loadState_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign extinct       = extinct_q;
  assign stepCount     = stepCount_q;
  assign infectedCount = infectedCount_q;
  assign peakCount     = peakCount_q;
  assign peakStep      = peakStep_q;

endmodule

// File: tb/tb_epidemic_sequencer.sv
// Directed and randomized runs of epidemic_sequencer against a per-run behavioural model.
module tb_epidemic_sequencer;
  localparam int          N      = 4;
  localparam logic [31:0] STRIDE = 32'h9E3779B9;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   baseSeed;
  logic [N-1:0]  infMask;
  logic [15:0]   maxSteps;
  logic [N-1:0]  nodeState;
  logic [1:0]    address;
  logic [31:0]   seedValue;
  logic          loadSeed, initState, loadState, busy, done, extinct;
  logic [15:0]   stepCount, peakStep;
  logic [2:0]    infectedCount, peakCount;

  int passed = 0;
  int fails  = 0;
  int total  = 0;
  logic [N-1:0] ns_q[$];

  epidemic_sequencer #(.N_NODES(N), .ADDR_W(2), .CNT_W(3), .SEED_STRIDE(STRIDE)) dut (
    .clk(clk), .rst(rst), .start(start), .baseSeed(baseSeed), .infMask(infMask),
    .maxSteps(maxSteps), .nodeState(nodeState), .address(address), .seedValue(seedValue),
    .loadSeed(loadSeed), .initState(initState), .loadState(loadState), .busy(busy),
    .done(done), .extinct(extinct), .stepCount(stepCount), .infectedCount(infectedCount),
    .peakCount(peakCount), .peakStep(peakStep)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " address"}, 32'(address), 32'h0);
    chk({tag, " seedValue"}, seedValue, 32'h0);
    chk({tag, " strobes"}, {29'h0, loadSeed, loadState, initState}, 32'h0);
    chk({tag, " busy/done/ext"}, {29'h0, busy, done, extinct}, 32'h0);
    chk({tag, " stepCount"}, 32'(stepCount), 32'h0);
    chk({tag, " counts"}, {26'h0, infectedCount, peakCount}, 32'h0);
    chk({tag, " peakStep"}, 32'(peakStep), 32'h0);
  endtask

  // Drives one complete run; expected values come from the run rules applied to ns_q.
  task automatic run_check(input logic [31:0] base, input logic [N-1:0] mask,
                           input logic [15:0] maxs, input bit poke, input string tag);
    logic [31:0] s;
    int p, peak, pstep, lastk;
    bit  fin, ext;
    baseSeed = base;
    infMask  = mask;
    maxSteps = maxs;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < N; j++) begin
      s = base + 32'(j) * STRIDE;
      if (s == 32'h0) s = 32'h1;
      chk({tag, " seed strobe"}, {30'h0, loadSeed, loadState}, 32'h2);
      chk({tag, " seed addr"}, 32'(address), 32'(j));
      chk({tag, " seed value"}, seedValue, s);
      chk({tag, " seed busy/done"}, {30'h0, busy, done}, 32'h2);
      if (poke && j == 1) begin
        start   = 1'b1;
        infMask = ~mask;
        maxSteps = 16'd7;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    for (int j = 0; j < N; j++) begin
      chk({tag, " state strobe"}, {30'h0, loadSeed, loadState}, 32'h1);
      chk({tag, " state addr"}, 32'(address), 32'(j));
      chk({tag, " initState"}, 32'(initState), 32'(mask[j]));
      chk({tag, " state done"}, 32'(done), 32'h0);
      tick();
    end
    peak = 0; pstep = 0; lastk = 0; ext = 1'b0;
    if (maxs == 16'd0) begin
      chk({tag, " zero-limit done"}, 32'(done), 32'h1);
      chk({tag, " zero-limit steps"}, 32'(stepCount), 32'h0);
      chk({tag, " zero-limit extinct"}, 32'(extinct), 32'h0);
    end else begin
      for (int k = 1; k <= ns_q.size(); k++) begin
        chk({tag, " run busy"}, 32'(busy), 32'h1);
        nodeState = ns_q[k-1];
        tick();
        p = $countones(ns_q[k-1]);
        if (p > peak) begin
          peak  = p;
          pstep = k;
        end
        ext   = (p == 0);
        fin   = ext || (k == int'(maxs));
        lastk = k;
        chk({tag, " infectedCount"}, 32'(infectedCount), 32'(p));
        chk({tag, " stepCount"}, 32'(stepCount), 32'(k));
        chk({tag, " peakCount"}, 32'(peakCount), 32'(peak));
        chk({tag, " peakStep"}, 32'(peakStep), 32'(pstep));
        chk({tag, " done"}, 32'(done), 32'(fin));
        if (fin) break;
      end
      chk({tag, " extinct"}, 32'(extinct), 32'(ext));
    end
    nodeState = '0;
    tick();
    chk({tag, " done single pulse"}, 32'(done), 32'h0);
    chk({tag, " idle busy"}, 32'(busy), 32'h0);
    chk({tag, " hold stepCount"}, 32'(stepCount), 32'(lastk));
    chk({tag, " hold peak"}, 32'(peakCount), 32'(peak));
    chk({tag, " hold extinct"}, 32'(extinct), 32'(ext));
    infMask = mask;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; baseSeed = '0; infMask = '0; maxSteps = '0; nodeState = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk_all_zero("reset");

    // Abandon a run mid-load, then replay it from node 0.
    baseSeed = 32'h1234_5678; infMask = 4'b1010; maxSteps = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("midload addr", 32'(address), 32'h2);
    chk("midload loadState", 32'(loadState), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("midload reset");
    ns_q = '{4'b0001, 4'b0011, 4'b0010};
    run_check(32'h1234_5678, 4'b1010, 16'd3, 1'b0, "replay");

    ns_q = '{4'b0011, 4'b0111, 4'b1111, 4'b0111, 4'b0001};
    run_check(32'h0000_0001, 4'b0110, 16'd5, 1'b0, "steplimit");
    chk("steplimit peak=4", 32'(peakCount), 32'h4);
    chk("steplimit peakStep=3", 32'(peakStep), 32'h3);

    ns_q = '{4'b1000};
    run_check(32'h0, 4'b1001, 16'd1, 1'b0, "zeroseed");

    ns_q = '{4'b0001, 4'b0000};
    run_check(32'hDEAD_BEEF, 4'b0001, 16'd100, 1'b0, "extinct");
    chk("extinct steps=2", 32'(stepCount), 32'h2);

    ns_q = '{4'b0001, 4'b0000};
    run_check(32'h5555_0000, 4'b0100, 16'd2, 1'b0, "extinct-at-limit");

    ns_q.delete();
    run_check(32'hCAFE_0001, 4'b1100, 16'd0, 1'b1, "zerolimit");

    for (int r = 0; r < 6; r++) begin
      logic [15:0] ms;
      ms = 16'($urandom_range(1, 9));
      ns_q.delete();
      for (int k = 0; k < int'(ms); k++) begin
        ns_q.push_back(($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(1, 15)));
      end
      run_check($urandom, 4'($urandom_range(0, 15)), ms, r[0], "random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
